// File: rtl/pi_pkg.sv
// Shared definitions for the pi slice engine.
//   - state_e     : frame FSM states
//   - pi_h        : centre offset H = (N+1)/2; also the inverse of 2 modulo odd N
//   - pi_idx      : lane (x,y) -> bit index row*N+col
//   - pi_fwd_dst  : bit index an input lane lands on under the forward map
//   - pi_inv_dst  : bit index an input lane lands on under the inverse map
package pi_pkg;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  function automatic int unsigned pi_h(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  // Lane (0,0) sits at the middle of the plane.
  function automatic int unsigned pi_idx(input int unsigned n, input int unsigned x,
                                         input int unsigned y);
    int unsigned h;
    h = pi_h(n);
    return ((y + n - h) % n) * n + ((x + n - h) % n);
  endfunction

  // in(x,y) -> out(y, (2x+3y) mod n)
  function automatic int unsigned pi_fwd_dst(input int unsigned n, input int unsigned x,
                                             input int unsigned y);
    return pi_idx(n, y, (2 * x + 3 * y) % n);
  endfunction

  // in(a,b) -> out(x,a) with 2x+3a == b (mod n); H is the inverse of 2 so x = (b-3a)*H.
  function automatic int unsigned pi_inv_dst(input int unsigned n, input int unsigned a,
                                             input int unsigned b);
    int unsigned x;
    x = (((b + 3 * (n - a)) % n) * pi_h(n)) % n;
    return pi_idx(n, x, a);
  endfunction

endpackage

// File: rtl/pi_slice_engine_if.sv
// Streaming bus of the pi slice engine: one valid/ready input channel carrying a slice and
// one valid/ready output channel carrying the permuted slice plus an end-of-frame tag.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : engine side (drives in_ready, out_*)
interface pi_slice_engine_if #(
  parameter int unsigned N = 5
) ();

  logic           in_valid;
  logic           in_ready;
  logic [N*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*N-1:0] out_data;
  logic           out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pi_slice_map.sv
// Combinational lane permutation of one N*N slice.
//   slice_i : input slice, bit index row*N+col
//   mode_i  : 0 forward map, 1 inverse map
//   slice_o : permuted slice
// Macro PI_SLICE_INVERSE_EN: when undefined only the forward map is built and mode_i is ignored.
module pi_slice_map
  import pi_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [N*N-1:0] slice_i,
  input  logic           mode_i,
  output logic [N*N-1:0] slice_o
);

  localparam int unsigned W    = N * N;
  localparam int unsigned IdxW = $clog2(W);

  logic [W-1:0] fwd;

  always_comb begin
    fwd = '0;
    for (int unsigned y = 0; y < N; y++) begin
      for (int unsigned x = 0; x < N; x++) begin
        fwd[IdxW'(pi_fwd_dst(N, x, y))] = slice_i[IdxW'(pi_idx(N, x, y))];
      end
    end
  end

`ifdef PI_SLICE_INVERSE_EN
  logic [W-1:0] inv;

  always_comb begin
    inv = '0;
    for (int unsigned y = 0; y < N; y++) begin
      for (int unsigned x = 0; x < N; x++) begin
        inv[IdxW'(pi_inv_dst(N, x, y))] = slice_i[IdxW'(pi_idx(N, x, y))];
      end
    end
  end

  assign slice_o = mode_i ? inv : fwd;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign slice_o     = fwd;
`endif

endmodule

// File: rtl/pi_slice_engine.sv
// Framed pi slice permutation engine: frame FSM, slice counter and a 2-entry output buffer
// around the combinational pi_slice_map.
//   clk, rst : clock, asynchronous active-high reset
//   mode     : 0 forward / 1 inverse, latched on the first slice of each frame
//   busy     : frame in progress or slices buffered
//   bus      : pi_slice_engine_if.slave (in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data/out_last)
// Macro PI_SLICE_INVERSE_EN: when undefined mode is ignored and the latched mode is always 0.
module pi_slice_engine
  import pi_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic             busy,
  pi_slice_engine_if.slave bus
);

  localparam int unsigned     W       = N * N;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [1:0]      occ_q, occ_d;
  logic [W-1:0]    data0_q, data0_d, data1_q, data1_d;
  logic            last0_q, last0_d, last1_q, last1_d;

  logic         push, pop, tag_last, mode_in, frame_mode;
  logic [1:0]   occ_after_pop;
  logic [W-1:0] mapped;

`ifdef PI_SLICE_INVERSE_EN
  assign mode_in = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_in     = 1'b0;
`endif

  // The first slice of a frame uses the live mode; the rest use the latched one.
  assign frame_mode = (state_q == StIdle) ? mode_in : mode_q;

  pi_slice_map #(
    .N(N)
  ) u_map (
    .slice_i(bus.in_data),
    .mode_i (frame_mode),
    .slice_o(mapped)
  );

  // Entry 0 is the head and drives the output directly.
  assign bus.in_ready  = (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = data0_q;
  assign bus.out_last  = last0_q & bus.out_valid;
  assign busy          = (state_q != StIdle) || (occ_q != 2'd0);

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    tag_last = 1'b0;
    if (push) begin
      unique case (state_q)
        StIdle: begin
          mode_d = frame_mode;
          if (DEPTH == 1) begin
            tag_last = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StActive;
          end
        end
        StActive: begin
          if (cnt_q == LastCnt) begin
            tag_last = 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A pop shifts entry 1 forward; a push then fills the first free slot, so a simultaneous
  // push and pop at occupancy 1 lands the new slice straight in the head.
  always_comb begin
    data0_d       = data0_q;
    data1_d       = data1_q;
    last0_d       = last0_q;
    last1_d       = last1_q;
    occ_after_pop = occ_q - {1'b0, pop};
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        data0_d = mapped;
        last0_d = tag_last;
      end else begin
        data1_d = mapped;
        last1_d = tag_last;
      end
    end
    occ_d = occ_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
    end
  end

endmodule

// File: tb/tb_pi_slice_engine.sv
// Directed bench for pi_slice_engine with N=5, DEPTH=4. Expected slices are hand-derived
// lane destinations for N=5 (H=3).
module tb_pi_slice_engine;

  localparam int unsigned N     = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = N * N;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic busy;

  pi_slice_engine_if #(.N(N)) bus ();

  pi_slice_engine #(
    .N    (N),
    .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .busy(busy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [W-1:0] t_in  [8];
  logic [W-1:0] t_out [8];

  function automatic logic [W-1:0] bit_at(input int n);
    logic [W-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    mode          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    mode          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0 ||
        bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b last=%b busy=%b data=%h ready=%b want 0 0 0 0 1",
               bus.out_valid, bus.out_last, busy, bus.out_data, bus.in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_forward();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = bit_at(13);
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== bit_at(22) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL forward_13: got valid=%b data=%h busy=%b want 1 %h 1",
               bus.out_valid, bus.out_data, busy, bit_at(22));
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL forward_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_centre();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      mode         = m[0];
      bus.in_valid = 1'b1;
      bus.in_data  = bit_at(12);
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== bit_at(12)) begin
        miscompares++;
        $display("FAIL centre_mode%0d: got valid=%b data=%h want 1 %h",
                 m, bus.out_valid, bus.out_data, bit_at(12));
      end
    end
  endtask

`ifdef PI_SLICE_INVERSE_EN
  task automatic test_inverse();
    logic [W-1:0] orig [4];
    logic [W-1:0] fwd  [4];
    do_reset();
    mode         = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = bit_at(22);
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== bit_at(13)) begin
      miscompares++;
      $display("FAIL inverse_22: got valid=%b data=%h want 1 %h",
               bus.out_valid, bus.out_data, bit_at(13));
    end
    do_reset();
    bus.out_ready = 1'b1;
    // Mode flips one slice into each frame and must be ignored until the next frame.
    for (int r = 0; r < 25; r++) begin
      mode = 1'b0;
      for (int k = 0; k < 4; k++) begin
        orig[k]      = W'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = orig[k];
        step();
        fwd[k] = bus.out_data;
        if (k == 0) mode = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        bus.in_data = fwd[k];
        step();
        if (k == 0) mode = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== orig[k]) begin
          miscompares++;
          $display("FAIL roundtrip[%0d][%0d]: got valid=%b data=%h want 1 %h",
                   r, k, bus.out_valid, bus.out_data, orig[k]);
        end
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask
`else
  task automatic test_mode_ignored();
    do_reset();
    mode         = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = bit_at(13);
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== bit_at(22)) begin
      miscompares++;
      $display("FAIL mode_ignored: got valid=%b data=%h want 1 %h",
               bus.out_valid, bus.out_data, bit_at(22));
    end
  endtask
`endif

  task automatic test_framing();
    logic exp_last;
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = t_in[k];
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL framing_ready[%0d]: got %b want 1", k, bus.in_ready);
      end
      step();
      exp_last = ((k % 4) == 3);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== t_out[k] || bus.out_last !== exp_last) begin
        miscompares++;
        $display("FAIL framing_out[%0d]: got valid=%b data=%h last=%b want 1 %h %b",
                 k, bus.out_valid, bus.out_data, bus.out_last, t_out[k], exp_last);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_idle: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = t_in[0];
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== t_out[0]) begin
      miscompares++;
      $display("FAIL bp_first: got ready=%b valid=%b data=%h want 1 1 %h",
               bus.in_ready, bus.out_valid, bus.out_data, t_out[0]);
    end
    bus.in_data = t_in[1];
    step();
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got in_ready=%b want 0", bus.in_ready);
    end
    bus.in_data = t_in[2];
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== t_out[0]) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b data=%h want 0 1 %h",
                 c, bus.in_ready, bus.out_valid, bus.out_data, t_out[0]);
      end
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_data !== t_out[1] || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release1: got data=%h ready=%b want %h 1",
               bus.out_data, bus.in_ready, t_out[1]);
    end
    step();
    vectors++;
    if (bus.out_data !== t_out[2] || bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release2: got data=%h last=%b want %h 0",
               bus.out_data, bus.out_last, t_out[2]);
    end
    bus.in_data = t_in[3];
    step();
    vectors++;
    if (bus.out_data !== t_out[3] || bus.out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release3: got data=%h last=%b want %h 1",
               bus.out_data, bus.out_last, t_out[3]);
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic exp_last;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = t_in[0];
    step();
    bus.in_data = t_in[1];
    step();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0 ||
        bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%b busy=%b data=%h ready=%b last=%b want 0 0 0 1 0",
               bus.out_valid, busy, bus.out_data, bus.in_ready, bus.out_last);
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = t_in[4+k];
      step();
      exp_last = (k == 3);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== t_out[4+k] || bus.out_last !== exp_last) begin
        miscompares++;
        $display("FAIL midreset_frame[%0d]: got valid=%b data=%h last=%b want 1 %h %b",
                 k, bus.out_valid, bus.out_data, bus.out_last, t_out[4+k], exp_last);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Forward destinations for N=5, worked by hand from the coordinate rule.
    t_in[0] = bit_at(0);                 t_out[0] = bit_at(10);
    t_in[1] = bit_at(1);                 t_out[1] = bit_at(20);
    t_in[2] = bit_at(7);                 t_out[2] = bit_at(21);
    t_in[3] = bit_at(12);                t_out[3] = bit_at(12);
    t_in[4] = bit_at(13);                t_out[4] = bit_at(22);
    t_in[5] = bit_at(24);                t_out[5] = bit_at(14);
    t_in[6] = bit_at(18);                t_out[6] = bit_at(13);
    t_in[7] = bit_at(6) | bit_at(2);     t_out[7] = bit_at(11) | bit_at(5);

    test_reset();
    test_forward();
    test_centre();
`ifdef PI_SLICE_INVERSE_EN
    test_inverse();
`else
    test_mode_ignored();
`endif
    test_framing();
    test_backpressure();
    test_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
